// File: rtl/s2mm_sched_pkg.sv
// Shared types and constants for the S2MM ring scheduler: FSM state
// encoding, page size, transfer length and DataMover command-word layout.
package s2mm_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERROR = 2'd3
    } sched_state_t;

    localparam int unsigned PAGE_BYTES = 4096;
    localparam int unsigned PAGE_SHIFT = 12;

    // Every command moves exactly one page
    localparam logic [22:0] CMD_BTT = 23'(PAGE_BYTES);

    // Command-word field offsets (72-bit S2MM command)
    localparam int unsigned CMD_W        = 72;
    localparam int unsigned CMD_BTT_LSB  = 0;
    localparam int unsigned CMD_TYPE_BIT = 23;
    localparam int unsigned CMD_DSA_LSB  = 24;
    localparam int unsigned CMD_EOF_BIT  = 30;
    localparam int unsigned CMD_DRE_BIT  = 31;
    localparam int unsigned CMD_ADDR_LSB = 32;
    localparam int unsigned CMD_TAG_LSB  = 64;

endpackage

// File: rtl/s2mm_cmd_builder.sv
// Combinational assembly of one 72-bit DataMover S2MM command word from a
// page address and tag. Reserved nibbles, DRE and DSA are always zero.
module s2mm_cmd_builder
    import s2mm_sched_pkg::*;
(
    input  logic [27:0]      addr,
    input  logic [3:0]       tag,
    output logic [CMD_W-1:0] cmd
);

    // Pack the fixed and variable fields into the command word
    always_comb begin
        cmd                           = '0;
        cmd[CMD_BTT_LSB +: 23]        = CMD_BTT;
        cmd[CMD_TYPE_BIT]             = 1'b1;
        cmd[CMD_DSA_LSB +: 6]         = 6'h00;
        cmd[CMD_EOF_BIT]              = 1'b1;
        cmd[CMD_DRE_BIT]              = 1'b0;
        cmd[CMD_ADDR_LSB +: 28]       = addr;
        cmd[CMD_TAG_LSB +: 4]         = tag;
    end

endmodule

// File: rtl/s2mm_ring_scheduler.sv
// S2MM ring scheduler: issues one-page DataMover write commands into a
// host ring buffer, tracks outstanding commands and completed pages, and
// flags ring overflow and DataMover errors.
// Optional build macro RING_OVERWRITE_EN: when defined, a full ring does not
// stall issue and overflow marks handshakes made while full; otherwise a
// full ring stalls issue and overflow marks every stalled ISSUE cycle.
module s2mm_ring_scheduler
    import s2mm_sched_pkg::*;
#(
    parameter int MAX_OUTST = 4
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    input  logic        enable,
    input  logic [27:0] ring_base,
    input  logic [15:0] ring_pages,
    input  logic [15:0] host_rd_page,
    input  logic        axis_cmd_tready,
    output logic        axis_cmd_tvalid,
    output logic [71:0] axis_cmd_tdata,
    input  logic        s2mm_wr_xfer_cmplt,
    input  logic        s2mm_err,
    output logic [15:0] wr_page,
    output logic [2:0]  outstanding,
    output logic        overflow,
    input  logic        overflow_clr,
    output logic        err_flag,
    output logic [1:0]  state
);

    localparam logic [2:0] MAX_Q = 3'(MAX_OUTST);

    sched_state_t state_q;
    logic [15:0]  pages_q;
    logic [15:0]  issue_ptr;
    logic [15:0]  issue_ptr_nxt;
    logic [15:0]  wr_page_nxt;
    logic [27:0]  cmd_addr;
    logic [71:0]  cmd_word;
    logic         ring_full;
    logic         handshake;
    logic         cmplt_cnt;
    logic         cmplt_stray;
    logic         issue_slot;
    logic         can_issue;
    logic         ovf_set;

    assign state = state_q;

    s2mm_cmd_builder u_cmd_builder (
        .addr (cmd_addr),
        .tag  (issue_ptr[3:0]),
        .cmd  (cmd_word)
    );

    // Ring pointer arithmetic, handshake/completion decode and issue gating
    always_comb begin
        issue_ptr_nxt = (issue_ptr == pages_q - 16'd1) ? '0 : issue_ptr + 16'd1;
        wr_page_nxt   = (wr_page == pages_q - 16'd1) ? '0 : wr_page + 16'd1;
        ring_full     = (issue_ptr_nxt == host_rd_page);
        cmd_addr      = {ring_base[27:PAGE_SHIFT], 12'h000} + {issue_ptr, 12'h000};
        handshake     = axis_cmd_tvalid && axis_cmd_tready;
        cmplt_cnt     = s2mm_wr_xfer_cmplt && (outstanding != 3'd0);
        cmplt_stray   = s2mm_wr_xfer_cmplt && (outstanding == 3'd0);
        // A new command is only considered once the previous one has left,
        // so the current pointer and count are always the ones to use.
        issue_slot    = (state_q == ST_ISSUE) && enable && !axis_cmd_tvalid;
`ifdef RING_OVERWRITE_EN
        can_issue     = issue_slot && (outstanding < MAX_Q);
        ovf_set       = handshake && ring_full;
`else
        can_issue     = issue_slot && (outstanding < MAX_Q) && !ring_full;
        ovf_set       = issue_slot && ring_full;
`endif
    end

    // Scheduler FSM with registered command channel and status counters
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state_q         <= ST_IDLE;
            axis_cmd_tvalid <= 1'b0;
            axis_cmd_tdata  <= '0;
            issue_ptr       <= '0;
            pages_q         <= '0;
            wr_page         <= '0;
            outstanding     <= '0;
            overflow        <= 1'b0;
            err_flag        <= 1'b0;
        end else begin
            outstanding <= outstanding + 3'(handshake) - 3'(cmplt_cnt);
            if (cmplt_stray) err_flag <= 1'b1;
            if (cmplt_cnt)   wr_page  <= wr_page_nxt;
            if (handshake)   issue_ptr <= issue_ptr_nxt;

            if (ovf_set)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q   <= ST_ISSUE;
                        pages_q   <= ring_pages;
                        issue_ptr <= '0;
                        wr_page   <= '0;
                        overflow  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (axis_cmd_tvalid) begin
                        if (axis_cmd_tready) axis_cmd_tvalid <= 1'b0;
                    end else if (can_issue) begin
                        axis_cmd_tvalid <= 1'b1;
                        axis_cmd_tdata  <= cmd_word;
                    end else if (!enable) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (outstanding == 3'd0) state_q <= ST_IDLE;
                end
                default: ;
            endcase

            if (s2mm_err) begin
                state_q         <= ST_ERROR;
                axis_cmd_tvalid <= 1'b0;
                err_flag        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_s2mm_ring_scheduler.sv
// Self-checking bench for s2mm_ring_scheduler: directed scenarios plus a
// randomized run against a page-count reference model.
module tb_s2mm_ring_scheduler;

    localparam int MAXO = 4;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn;
    logic        enable;
    logic [27:0] ring_base;
    logic [15:0] ring_pages;
    logic [15:0] host_rd_page;
    logic        axis_cmd_tready;
    logic        axis_cmd_tvalid;
    logic [71:0] axis_cmd_tdata;
    logic        s2mm_wr_xfer_cmplt;
    logic        s2mm_err;
    logic [15:0] wr_page;
    logic [2:0]  outstanding;
    logic        overflow;
    logic        overflow_clr;
    logic        err_flag;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    // Reference model: commands accepted since the run started, completions
    logic [71:0] hs_q[$];
    int unsigned m_pages = 2;
    int unsigned m_base  = 0;
    int unsigned m_wr    = 0;
    logic [2:0]  m_out   = '0;

    s2mm_ring_scheduler #(.MAX_OUTST(MAXO)) dut (
        .axi_aclk           (axi_aclk),
        .axi_aresetn        (axi_aresetn),
        .enable             (enable),
        .ring_base          (ring_base),
        .ring_pages         (ring_pages),
        .host_rd_page       (host_rd_page),
        .axis_cmd_tready    (axis_cmd_tready),
        .axis_cmd_tvalid    (axis_cmd_tvalid),
        .axis_cmd_tdata     (axis_cmd_tdata),
        .s2mm_wr_xfer_cmplt (s2mm_wr_xfer_cmplt),
        .s2mm_err           (s2mm_err),
        .wr_page            (wr_page),
        .outstanding        (outstanding),
        .overflow           (overflow),
        .overflow_clr       (overflow_clr),
        .err_flag           (err_flag),
        .state              (state)
    );

    always #5 axi_aclk = ~axi_aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Expected k-th command word of the current run
    function automatic logic [71:0] exp_word(input int unsigned k);
        int unsigned idx;
        logic [31:0] a;
        logic [3:0]  t;
        idx = k % m_pages;
        a   = (m_base / 32'd4096) * 32'd4096 + idx * 32'd4096;
        t   = idx[3:0];
        return {4'h0, t, 4'h0, a[27:0], 1'b0, 1'b1, 6'h00, 1'b1, 23'h001000};
    endfunction

    function automatic logic model_full();
        return (((hs_q.size() + 1) % m_pages) == int'(host_rd_page));
    endfunction

    // Advance one clock: log the handshake/completion due at this edge
    task automatic step();
        logic hs, cnt;
        hs  = axis_cmd_tvalid && axis_cmd_tready;
        cnt = s2mm_wr_xfer_cmplt && (m_out != 3'd0);
        if (hs) hs_q.push_back(axis_cmd_tdata);
        if (cnt) m_wr = (m_wr + 1) % m_pages;
        m_out = m_out + 3'(hs) - 3'(cnt);
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic do_reset();
        axi_aresetn        = 1'b0;
        enable             = 1'b0;
        axis_cmd_tready    = 1'b0;
        s2mm_wr_xfer_cmplt = 1'b0;
        s2mm_err           = 1'b0;
        overflow_clr       = 1'b0;
        host_rd_page       = '0;
        step();
        step();
        m_out = '0;
        m_wr  = 0;
        hs_q.delete();
        axi_aresetn = 1'b1;
    endtask

    task automatic start(input logic [27:0] base, input logic [15:0] pages);
        ring_base  = base;
        ring_pages = pages;
        m_base     = 32'(base);
        m_pages    = 32'(pages);
        m_wr       = 0;
        hs_q.delete();
        enable     = 1'b1;
    endtask

    task automatic test_reset();
        axi_aresetn        = 1'b0;
        enable             = 1'b1;
        axis_cmd_tready    = 1'b1;
        s2mm_wr_xfer_cmplt = 1'b1;
        s2mm_err           = 1'b0;
        overflow_clr       = 1'b0;
        ring_base          = 28'h1234000;
        ring_pages         = 16'd4;
        host_rd_page       = '0;
        step();
        step();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        total++; if (axis_cmd_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", axis_cmd_tvalid); end
        total++; if (axis_cmd_tdata !== 72'h0) begin bad++; $display("FAIL reset_tdata: got %h want 0", axis_cmd_tdata); end
        total++; if (wr_page !== 16'd0) begin bad++; $display("FAIL reset_wr_page: got %0d want 0", wr_page); end
        total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        total++; if (overflow !== 1'b0 || err_flag !== 1'b0) begin bad++; $display("FAIL reset_flags: got ovf=%b err=%b want 0 0", overflow, err_flag); end
    endtask

    task automatic test_ring_full();
        do_reset();
        axis_cmd_tready = 1'b1;
        start(28'h0100000, 16'd4);
        for (int i = 0; i < 40; i++) begin
            s2mm_wr_xfer_cmplt = (m_out != 3'd0);
            step();
        end
        s2mm_wr_xfer_cmplt = 1'b0;
`ifndef RING_OVERWRITE_EN
        total++; if (hs_q.size() != 3) begin bad++; $display("FAIL full_count: got %0d want 3", hs_q.size()); end
        total++; if (wr_page !== 16'd3) begin bad++; $display("FAIL full_wr_page: got %0d want 3", wr_page); end
`endif
        for (int k = 0; k < 3 && k < hs_q.size(); k++) begin
            total++; if (hs_q[k] !== exp_word(k)) begin bad++; $display("FAIL full_word%0d: got %h want %h", k, hs_q[k], exp_word(k)); end
        end
        if (hs_q.size() > 2) begin
            total++; if (hs_q[2][59:32] !== 28'h0102000) begin bad++; $display("FAIL full_addr2: got %h want 0102000", hs_q[2][59:32]); end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_overflow: got %b want 1", overflow); end
`ifndef RING_OVERWRITE_EN
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
`endif
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s2mm_wr_xfer_cmplt = (m_out != 3'd0);
            step();
        end
        s2mm_wr_xfer_cmplt = 1'b0;
        total++; if (state !== 2'd0) begin bad++; $display("FAIL full_idle: got %0d want 0", state); end
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        axis_cmd_tready = 1'b1;
        start(28'h0100000, 16'd4);
        for (int i = 0; i < 80 && hs_q.size() < 5; i++) begin
            n = hs_q.size();
            host_rd_page       = 16'((n < 3) ? n : 3);
            s2mm_wr_xfer_cmplt = (m_out != 3'd0);
            step();
        end
        enable = 1'b0;
        total++; if (hs_q.size() != 5) begin bad++; $display("FAIL wrap_count: got %0d want 5", hs_q.size()); end
        for (int k = 0; k < hs_q.size(); k++) begin
            total++; if (hs_q[k] !== exp_word(k)) begin bad++; $display("FAIL wrap_word%0d: got %h want %h", k, hs_q[k], exp_word(k)); end
        end
        if (hs_q.size() > 4) begin
            total++; if (hs_q[4][59:32] !== 28'h0100000) begin bad++; $display("FAIL wrap_addr4: got %h want 0100000", hs_q[4][59:32]); end
        end
        for (int i = 0; i < 20 && state !== 2'd0; i++) begin
            s2mm_wr_xfer_cmplt = (m_out != 3'd0);
            step();
        end
        s2mm_wr_xfer_cmplt = 1'b0;
        total++; if (state !== 2'd0) begin bad++; $display("FAIL wrap_idle: got %0d want 0", state); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL wrap_overflow: got %b want 0", overflow); end
        total++; if (wr_page !== 16'(m_wr)) begin bad++; $display("FAIL wrap_wr_page: got %0d want %0d", wr_page, m_wr); end
    endtask

    task automatic test_max_outst();
        int viol;
        viol = 0;
        do_reset();
        axis_cmd_tready = 1'b1;
        start(28'h0340000, 16'd16);
        for (int i = 0; i < 30; i++) begin
            step();
            if (axis_cmd_tvalid && m_out == 3'(MAXO)) viol++;
        end
        total++; if (hs_q.size() != MAXO) begin bad++; $display("FAIL max_count: got %0d want %0d", hs_q.size(), MAXO); end
        total++; if (outstanding !== 3'(MAXO)) begin bad++; $display("FAIL max_outstanding: got %0d want %0d", outstanding, MAXO); end
        total++; if (viol != 0 || axis_cmd_tvalid !== 1'b0) begin bad++; $display("FAIL max_tvalid: got viol=%0d tvalid=%b want 0 0", viol, axis_cmd_tvalid); end
        s2mm_wr_xfer_cmplt = 1'b1;
        step();
        s2mm_wr_xfer_cmplt = 1'b0;
        total++; if (outstanding !== 3'(MAXO - 1)) begin bad++; $display("FAIL max_after_cmplt: got %0d want %0d", outstanding, MAXO - 1); end
        for (int i = 0; i < 8 && hs_q.size() < MAXO + 1; i++) step();
        total++; if (hs_q.size() != MAXO + 1) begin bad++; $display("FAIL max_resume: got %0d want %0d", hs_q.size(), MAXO + 1); end
        if (hs_q.size() > MAXO) begin
            total++; if (hs_q[MAXO] !== exp_word(MAXO)) begin bad++; $display("FAIL max_word: got %h want %h", hs_q[MAXO], exp_word(MAXO)); end
        end
        axi_aresetn = 1'b0;
        enable      = 1'b0;
        step();
        total++; if (outstanding !== 3'd0 || state !== 2'd0 || axis_cmd_tvalid !== 1'b0) begin
            bad++; $display("FAIL midreset: got out=%0d st=%0d tv=%b want 0 0 0", outstanding, state, axis_cmd_tvalid);
        end
        axi_aresetn = 1'b1;
    endtask

    task automatic test_enable_drop();
        logic [71:0] cap;
        do_reset();
        start(28'h0A53000, 16'd8);
        for (int i = 0; i < 10 && axis_cmd_tvalid !== 1'b1; i++) step();
        cap = axis_cmd_tdata;
        total++; if (axis_cmd_tvalid !== 1'b1 || cap !== exp_word(0)) begin bad++; $display("FAIL drop_first: got tv=%b %h want 1 %h", axis_cmd_tvalid, cap, exp_word(0)); end
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (axis_cmd_tvalid !== 1'b1 || axis_cmd_tdata !== cap) begin
                bad++; $display("FAIL drop_hold%0d: got tv=%b %h want 1 %h", i, axis_cmd_tvalid, axis_cmd_tdata, cap);
            end
        end
        axis_cmd_tready = 1'b1;
        step();
        axis_cmd_tready = 1'b0;
        total++; if (hs_q.size() != 1 || axis_cmd_tvalid !== 1'b0) begin bad++; $display("FAIL drop_hs: got n=%0d tv=%b want 1 0", hs_q.size(), axis_cmd_tvalid); end
        step();
        total++; if (state !== 2'd2) begin bad++; $display("FAIL drop_drain: got %0d want 2", state); end
        step();
        step();
        total++; if (state !== 2'd2) begin bad++; $display("FAIL drop_wait: got %0d want 2", state); end
        s2mm_wr_xfer_cmplt = 1'b1;
        step();
        s2mm_wr_xfer_cmplt = 1'b0;
        for (int i = 0; i < 4 && state !== 2'd0; i++) step();
        total++; if (state !== 2'd0 || outstanding !== 3'd0) begin bad++; $display("FAIL drop_idle: got st=%0d out=%0d want 0 0", state, outstanding); end
        total++; if (hs_q.size() != 1) begin bad++; $display("FAIL drop_single: got %0d want 1", hs_q.size()); end
    endtask

    task automatic test_error();
        do_reset();
        start(28'h0200000, 16'd8);
        for (int i = 0; i < 10 && axis_cmd_tvalid !== 1'b1; i++) step();
        s2mm_err = 1'b1;
        step();
        s2mm_err = 1'b0;
        total++; if (state !== 2'd3) begin bad++; $display("FAIL err_state: got %0d want 3", state); end
        total++; if (axis_cmd_tvalid !== 1'b0 || err_flag !== 1'b1) begin bad++; $display("FAIL err_outputs: got tv=%b err=%b want 0 1", axis_cmd_tvalid, err_flag); end
        enable          = 1'b0;
        axis_cmd_tready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        total++; if (state !== 2'd3 || axis_cmd_tvalid !== 1'b0) begin bad++; $display("FAIL err_sticky: got st=%0d tv=%b want 3 0", state, axis_cmd_tvalid); end
        axi_aresetn = 1'b0;
        step();
        axi_aresetn = 1'b1;
        step();
        total++; if (state !== 2'd0 || err_flag !== 1'b0) begin bad++; $display("FAIL err_reset: got st=%0d err=%b want 0 0", state, err_flag); end
    endtask

    task automatic test_back_to_back();
        logic done;
        done = 1'b0;
        do_reset();
        axis_cmd_tready = 1'b1;
        start(28'h0400000, 16'd16);
        for (int i = 0; i < 20 && !done; i++) begin
            s2mm_wr_xfer_cmplt = axis_cmd_tvalid && (m_out == 3'd2);
            done = s2mm_wr_xfer_cmplt;
            step();
        end
        s2mm_wr_xfer_cmplt = 1'b0;
        total++; if (!done || outstanding !== 3'd2) begin bad++; $display("FAIL same_cycle: got done=%b out=%0d want 1 2", done, outstanding); end
        enable = 1'b0;
        for (int i = 0; i < 20 && (m_out != 3'd0 || state !== 2'd0); i++) begin
            s2mm_wr_xfer_cmplt = (m_out != 3'd0);
            step();
        end
        s2mm_wr_xfer_cmplt = 1'b0;
        total++; if (outstanding !== 3'd0 || err_flag !== 1'b0) begin bad++; $display("FAIL drained: got out=%0d err=%b want 0 0", outstanding, err_flag); end
        s2mm_wr_xfer_cmplt = 1'b1;
        step();
        s2mm_wr_xfer_cmplt = 1'b0;
        total++; if (err_flag !== 1'b1 || outstanding !== 3'd0) begin bad++; $display("FAIL stray_cmplt: got err=%b out=%0d want 1 0", err_flag, outstanding); end
        total++; if (wr_page !== 16'(m_wr)) begin bad++; $display("FAIL stray_wr_page: got %0d want %0d", wr_page, m_wr); end
    endtask

    task automatic test_random();
        int unsigned pages;
        int nbad_out, nbad_wr, nbad_word, nbad_lim, nbad_full;
        for (int r = 0; r < 4; r++) begin
            nbad_out = 0; nbad_wr = 0; nbad_word = 0; nbad_lim = 0; nbad_full = 0;
            do_reset();
            pages = $urandom_range(2, 40);
            start(28'($urandom), 16'(pages));
            for (int i = 0; i < 300; i++) begin
                axis_cmd_tready    = ($urandom % 3) != 0;
                s2mm_wr_xfer_cmplt = (m_out != 3'd0) && (($urandom % 2) == 0);
                if (axis_cmd_tvalid !== 1'b1 && ($urandom % 16) == 0)
                    host_rd_page = 16'($urandom_range(0, pages - 1));
                step();
                if (i < 2) continue;
                if (outstanding !== m_out) nbad_out++;
                if (wr_page !== 16'(m_wr)) nbad_wr++;
                if (axis_cmd_tvalid === 1'b1) begin
                    if (axis_cmd_tdata !== exp_word(hs_q.size())) nbad_word++;
                    if (m_out >= 3'(MAXO)) nbad_lim++;
`ifndef RING_OVERWRITE_EN
                    if (model_full()) nbad_full++;
`endif
                end
            end
            total++; if (nbad_out != 0) begin bad++; $display("FAIL rnd%0d_outstanding: got %0d bad cycles want 0", r, nbad_out); end
            total++; if (nbad_wr != 0) begin bad++; $display("FAIL rnd%0d_wr_page: got %0d bad cycles want 0", r, nbad_wr); end
            total++; if (nbad_word != 0) begin bad++; $display("FAIL rnd%0d_tdata: got %0d bad cycles want 0", r, nbad_word); end
            total++; if (nbad_lim != 0 || nbad_full != 0) begin bad++; $display("FAIL rnd%0d_gating: got lim=%0d full=%0d want 0 0", r, nbad_lim, nbad_full); end
            total++; if (hs_q.size() < 5 || err_flag !== 1'b0) begin bad++; $display("FAIL rnd%0d_progress: got n=%0d err=%b want >=5 0", r, hs_q.size(), err_flag); end
        end
    endtask

    initial begin
        test_reset();
        test_ring_full();
        test_wrap();
        test_max_outst();
        test_enable_drop();
        test_error();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/s2mm_ring_scheduler.md
S2MM_RING_SCHEDULER -- requirements
Module: s2mm_ring_scheduler

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 4, maximum DataMover commands outstanding (2..7).
REQ-002 SHALL have port axi_aclk  in  1  sole clock, all logic rising-edge.
REQ-003 SHALL have port axi_aresetn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port enable  in  1  run request from control GPIO.
REQ-005 SHALL have port ring_base  in  28  ring start byte address, bits [11:0] ignored (4 KiB aligned).
REQ-006 SHALL have port ring_pages  in  16  ring size in 4 KiB pages, valid 2..65535; sampled on IDLE->ISSUE.
REQ-007 SHALL have port host_rd_page  in  16  host consumer page index.
REQ-008 SHALL have port axis_cmd_tready  in  1  DataMover command ready.
REQ-009 SHALL have port axis_cmd_tvalid  out  1  command valid.
REQ-010 SHALL have port axis_cmd_tdata  out  72  S2MM command word.
REQ-011 SHALL have port s2mm_wr_xfer_cmplt  in  1  one-cycle completion pulse.
REQ-012 SHALL have port s2mm_err  in  1  DataMover error.
REQ-013 SHALL have ports wr_page out 16 (next page to complete), outstanding out 3, overflow out 1 (sticky), overflow_clr in 1, err_flag out 1 (sticky), state out 2.

Function
REQ-014 SHALL run FSM IDLE(0), ISSUE(1), DRAIN(2), ERROR(3), encoded on state.
REQ-015 IDLE->ISSUE SHALL occur when enable=1; issue_ptr, wr_page and overflow SHALL clear on that transition.
REQ-016 In ISSUE, axis_cmd_tvalid SHALL assert when outstanding<MAX_OUTST and the ring is not full; tdata registered, one-cycle latency.
REQ-017 Once asserted, tvalid and tdata SHALL hold stable until tready=1, regardless of enable.
REQ-018 tdata SHALL be {4'h0, issue_ptr[3:0] tag, 4'h0, addr[27:0], DRE=0, EOF=1, DSA=6'h00, Type=1, BTT=23'h001000}.
REQ-019 addr SHALL equal {ring_base[27:12],12'h000} + {issue_ptr,12'h000}, truncated to 28 bits.
REQ-020 On handshake issue_ptr SHALL increment, wrapping from ring_pages-1 to 0.
REQ-021 Ring full SHALL mean (issue_ptr+1) mod ring_pages == host_rd_page.
REQ-022 outstanding SHALL increment on handshake, decrement on cmplt, and remain unchanged when both occur in the same cycle.
REQ-023 cmplt with outstanding=0 SHALL be ignored and set err_flag.
REQ-024 On each counted cmplt, wr_page SHALL increment modulo ring_pages.
REQ-025 ISSUE->DRAIN SHALL occur when enable=0 and no handshake is pending; DRAIN->IDLE when outstanding=0.
REQ-026 s2mm_err=1 in any state SHALL force ERROR next cycle, drop tvalid, set err_flag; ERROR exits only by reset.
REQ-027 overflow_clr SHALL clear overflow; a simultaneous set SHALL win.

Reset
REQ-028 With axi_aresetn=0 at a clock edge: state=IDLE, tvalid=0, tdata=0, issue_ptr=0, wr_page=0, outstanding=0, overflow=0, err_flag=0.
REQ-029 Reset mid-transfer SHALL discard outstanding count without waiting for completions.

Configuration
REQ-030 Macro RING_OVERWRITE_EN defined: ring-full SHALL NOT stall issue; each handshake made while full SHALL set overflow.
REQ-031 Macro undefined: ring-full SHALL stall issue; overflow SHALL set on any ISSUE cycle stalled by ring-full.

Structure
REQ-032 Package s2mm_sched_pkg SHALL hold the state enum, PAGE_BYTES=4096, BTT constant and the command-word field offsets.
REQ-033 Sub-module s2mm_cmd_builder (addr/tag/fields -> 72-bit word, combinational) SHALL be the only sub-module.

Verification
REQ-034 base=0x0100000, pages=4, host_rd=0, tready=1, cmplt after each -> 3 commands at 0x0100000, 0x0101000, 0x0102000, then stall, overflow=1 (no macro).
REQ-035 Same, host_rd steps 1,2,3 -> addresses wrap to 0x0100000 after 0x0103000; overflow stays 0.
REQ-036 No cmplt, MAX_OUTST=4 -> exactly 4 handshakes, outstanding=4, tvalid=0 until one cmplt.
REQ-037 enable drops while tvalid=1, tready=0 for 5 cycles -> tdata stable, one handshake, DRAIN, IDLE after last cmplt.
REQ-038 s2mm_err pulse during ISSUE -> state=3, tvalid=0, err_flag=1; only axi_aresetn=0 returns to IDLE.
REQ-039 Handshake and cmplt in same cycle with outstanding=2 -> outstanding stays 2; stray cmplt at 0 -> err_flag=1.
